reg_file_8x_rd_encoder: RTL and testbench

- 8-entry register file that receives its write select as the one-hot vector produced by the 3-to-8 address decoder.
- Performs the inverse (8-to-3) encoding to report the last written address and to flag illegal write selects.
- Serves two registered read ports through a request/valid handshake with write-first bypass.
- Sits between the decoder/write path and the datapath read operands.

---
 rtl/reg_file_8x_rd_encoder_if.sv | 27 ++
 rtl/reg_file_8x_rd_encoder.sv | 72 +++++++
 tb/tb_reg_file_8x_rd_encoder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/reg_file_8x_rd_encoder_if.sv
// Write/read bus of the 8-entry register file: decoder-driven one-hot write select,
// dual-address read request and the registered read/status returns.
interface reg_file_8x_rd_encoder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  we;
  logic [7:0]            we_onehot;
  logic [DATA_WIDTH-1:0] wData;
  logic                  rd_req;
  logic [2:0]            rAddrA;
  logic [2:0]            rAddrB;
  logic [DATA_WIDTH-1:0] rData_A;
  logic [DATA_WIDTH-1:0] rData_B;
  logic                  rd_valid;
  logic [2:0]            last_wAddr;
  logic                  we_err;

  modport master (
    output we, we_onehot, wData, rd_req, rAddrA, rAddrB,
    input  rData_A, rData_B, rd_valid, last_wAddr, we_err
  );

  modport slave (
    input  we, we_onehot, wData, rd_req, rAddrA, rAddrB,
    output rData_A, rData_B, rd_valid, last_wAddr, we_err
  );
endinterface

// File: rtl/reg_file_8x_rd_encoder.sv
// 8-entry register file written through a one-hot select; encodes the select back to
// a binary index, flags illegal selects and serves two registered write-first read ports.
module reg_file_8x_rd_encoder #(
  parameter int DATA_WIDTH = 32
) (
  input logic                     clk,
  input logic                     reset_n,
  reg_file_8x_rd_encoder_if.slave bus
);

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

  function automatic logic [2:0] enc8to3(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [8];
  logic [DATA_WIDTH-1:0] r_rdata_a;
  logic [DATA_WIDTH-1:0] r_rdata_b;
  logic                  r_rd_valid;
  logic [2:0]            r_last_waddr;
  logic                  r_we_err;

  logic                  w_sel_ok;
  logic                  w_wr_ok;
  logic [2:0]            w_waddr;
  logic [DATA_WIDTH-1:0] w_rd_a;
  logic [DATA_WIDTH-1:0] w_rd_b;

  assign w_sel_ok = is_onehot(bus.we_onehot);
  assign w_wr_ok  = bus.we && w_sel_ok;
  assign w_waddr  = enc8to3(bus.we_onehot);

  // Write-first: a legal write to the addressed entry overtakes the stored value
  assign w_rd_a = (w_wr_ok && (w_waddr == bus.rAddrA)) ? bus.wData : r_mem[bus.rAddrA];
  assign w_rd_b = (w_wr_ok && (w_waddr == bus.rAddrB)) ? bus.wData : r_mem[bus.rAddrB];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) r_mem[i] <= '0;
      r_rdata_a    <= '0;
      r_rdata_b    <= '0;
      r_rd_valid   <= 1'b0;
      r_last_waddr <= 3'd0;
      r_we_err     <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_mem[w_waddr] <= bus.wData;
        r_last_waddr   <= w_waddr;
      end
      r_we_err   <= bus.we && !w_sel_ok;
      r_rd_valid <= bus.rd_req;
      if (bus.rd_req) begin
        r_rdata_a <= w_rd_a;
        r_rdata_b <= w_rd_b;
      end
    end
  end

  assign bus.rData_A    = r_rdata_a;
  assign bus.rData_B    = r_rdata_b;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.last_wAddr = r_last_waddr;
  assign bus.we_err     = r_we_err;

endmodule

// File: tb/tb_reg_file_8x_rd_encoder.sv
// Scoreboard bench for reg_file_8x_rd_encoder: read expectations are queued at the
// request edge and compared when rd_valid appears one cycle later.
module tb_reg_file_8x_rd_encoder;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  reg_file_8x_rd_encoder_if #(.DATA_WIDTH(32)) bus ();

  reg_file_8x_rd_encoder #(.DATA_WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] mem_m [8];
  logic [2:0]  last_m;
  logic        err_m;
  logic [31:0] hold_a, hold_b;
  logic [63:0] sb_q [$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, then check the outputs.
  task automatic step(input logic rst_n, input logic we, input logic [7:0] oh,
                      input logic [31:0] wd, input logic rd,
                      input logic [2:0] a, input logic [2:0] b);
    logic        legal;
    int          ones;
    logic [2:0]  idx;
    logic [63:0] e;
    reset_n       = rst_n;
    bus.we        = we;
    bus.we_onehot = oh;
    bus.wData     = wd;
    bus.rd_req    = rd;
    bus.rAddrA    = a;
    bus.rAddrB    = b;
    ones = 0;
    idx  = 3'd0;
    for (int i = 0; i < 8; i++) if (oh[i]) begin ones++; idx = 3'(i); end
    legal = we && (ones == 1);
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem_m[i] = 32'h0;
      last_m = 3'd0;
      err_m  = 1'b0;
      hold_a = 32'h0;
      hold_b = 32'h0;
    end else begin
      if (rd)
        sb_q.push_back({(legal && idx == a) ? wd : mem_m[a],
                        (legal && idx == b) ? wd : mem_m[b]});
      if (legal) begin
        mem_m[idx] = wd;
        last_m     = idx;
      end
      err_m = we && !legal;
    end
    #1;
    check("rd_valid", 64'(bus.rd_valid), 64'(rst_n && rd));
    if (bus.rd_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'(1), 64'(0));
      end else begin
        e = sb_q.pop_front();
        check("rData_A", 64'(bus.rData_A), 64'(e[63:32]));
        check("rData_B", 64'(bus.rData_B), 64'(e[31:0]));
        hold_a = e[63:32];
        hold_b = e[31:0];
      end
    end else begin
      check("rData_A_hold", 64'(bus.rData_A), 64'(hold_a));
      check("rData_B_hold", 64'(bus.rData_B), 64'(hold_b));
    end
    check("last_wAddr", 64'(bus.last_wAddr), 64'(last_m));
    check("we_err", 64'(bus.we_err), 64'(err_m));
  endtask

  initial begin
    reset_n = 1'b0;
    bus.we = 1'b0; bus.we_onehot = 8'h00; bus.wData = '0;
    bus.rd_req = 1'b0; bus.rAddrA = '0; bus.rAddrB = '0;
    for (int i = 0; i < 8; i++) mem_m[i] = 32'hX;
    last_m = 3'd0; err_m = 1'b0; hold_a = 32'h0; hold_b = 32'h0;

    // 1: reset overrides write and read
    repeat (2) step(1'b0, 1'b1, 8'h01, 32'hFFFF_FFFF, 1'b1, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 3'(i), 3'(7 - i));
    step(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 3'd0, 3'd0);

    // 2: write sweep then read sweep
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 8'(1 << i), 32'hA5A5_0000 + i, 1'b0, 3'd0, 3'd0);
    check("last_wAddr_sweep", 64'(bus.last_wAddr), 64'd7);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 3'(i), 3'(7 - i));
    step(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 3'd0, 3'd0);
    check("sweep_data_5", 64'(mem_m[5]), 64'h0000_0000_A5A5_0005);

    // 3: illegal selects, with a read of entry 0 alongside (no bypass allowed)
    step(1'b1, 1'b1, 8'h00, 32'hDEAD_BEEF, 1'b0, 3'd0, 3'd0);
    step(1'b1, 1'b1, 8'h11, 32'hDEAD_BEEF, 1'b1, 3'd0, 3'd4);
    step(1'b1, 1'b1, 8'hFF, 32'hDEAD_BEEF, 1'b0, 3'd0, 3'd0);
    check("we_err_ff", 64'(bus.we_err), 64'd1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 3'(i), 3'(7 - i));
    step(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 3'd0, 3'd0);

    // 4: same-cycle write and read of entry 3
    step(1'b1, 1'b1, 8'h08, 32'h1234_5678, 1'b1, 3'd3, 3'd3);
    check("bypass_A", 64'(bus.rData_A), 64'h1234_5678);
    check("bypass_B", 64'(bus.rData_B), 64'h1234_5678);
    // write to 6 while reading 2/5 is independent
    step(1'b1, 1'b1, 8'h40, 32'h0BAD_F00D, 1'b1, 3'd2, 3'd5);

    // 5: streaming then hold
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 3'(i), 3'(i + 4));
    step(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 3'd7, 3'd7);
    step(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 3'd7, 3'd7);
    check("hold_entry3", 64'(bus.rData_A), 64'h1234_5678);

    // 6: reset at the same edge as a read request
    step(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 3'd3, 3'd6);
    step(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 3'd3, 3'd6);
    check("rst_mid_rdA", 64'(bus.rData_A), 64'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 3'(i), 3'(7 - i));
    step(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 3'd0, 3'd0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
